// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared state encoding and default widths for the data memory
package data_ram_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  typedef enum logic {ST_CLEAR, ST_IDLE} dram_state_t;
endpackage

// File: rtl/data_ram_sync_if.sv
// data_ram_sync_if: request/response bus between load/store stage (master) and data RAM (slave)
//   Req/MemWrite/Address/WriteData  master -> slave request
//   Ready/MemOut/RdValid/AddrErr    slave -> master response
interface data_ram_sync_if
  import data_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic Req;
  logic MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic Ready;
  logic [DATA_W-1:0] MemOut;
  logic RdValid;
  logic AddrErr;
  modport master(output Req, MemWrite, Address, WriteData, input Ready, MemOut, RdValid, AddrErr);
  modport slave(input Req, MemWrite, Address, WriteData, output Ready, MemOut, RdValid, AddrErr);
endinterface

// File: rtl/data_ram_array.sv
// data_ram_array: plain storage, one write port and one registered read port, no reset
//   we/wa/wd  write port, mem[wa] <= wd on posedge when we
//   re/ra/rd  read port, rd <= mem[ra] on posedge when re, otherwise rd holds
module data_ram_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 256,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [AW-1:0]     ra,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/data_ram_sync.sv
// data_ram_sync: data memory with registered read, req/ready handshake, clear sweep and range check
//   CLK/Reset  clock and synchronous active-high reset
//   bus        slave side of data_ram_sync_if (request in, Ready/MemOut/RdValid/AddrErr out)
module data_ram_sync
  import data_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH = 1 << ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic CLK,
  input logic Reset,
  data_ram_sync_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  dram_state_t state, state_nx;
  logic [CW-1:0] clr_cnt;
  logic accept, oor, we, re, zero_q;
  logic [AW-1:0] wa;
  logic [DATA_W-1:0] wd, rd;
  assign oor = int'(bus.Address) >= DEPTH;
  assign accept = bus.Req && bus.Ready;
  always_comb begin
    bus.Ready = state == ST_IDLE && !Reset;
    state_nx = state == ST_CLEAR && clr_cnt == CW'(DEPTH - 1) ? ST_IDLE : state;
    we = (state == ST_CLEAR && !Reset) || (accept && bus.MemWrite && !oor);
    wa = state == ST_CLEAR ? clr_cnt[AW-1:0] : bus.Address[AW-1:0];
    wd = state == ST_CLEAR ? '0 : bus.WriteData;
    re = accept && !bus.MemWrite && !oor;
  end
  always_ff @(posedge CLK) begin
    state <= Reset ? (CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE) : state_nx;
    clr_cnt <= Reset ? '0 : state == ST_CLEAR ? clr_cnt + CW'(1) : clr_cnt;
    bus.RdValid <= !Reset && accept && !bus.MemWrite;
    bus.AddrErr <= !Reset && accept && oor;
    // the array read register has no reset, so reset and out-of-range reads force zero here
    zero_q <= Reset ? 1'b1 : accept && !bus.MemWrite ? oor : zero_q;
  end
  assign bus.MemOut = zero_q ? '0 : rd;
  data_ram_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk(CLK), .we(we), .wa(wa), .wd(wd), .re(re), .ra(bus.Address[AW-1:0]), .rd(rd)
  );
endmodule
